// File: rtl/rv32i_ctrl_pkg.sv
// Shared control definitions for the RV32I core: hazard FSM states, major
// opcodes used by the decoder, and the hard-wired zero register index.
package rv32i_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } hazard_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use hazard compare between the ID operands and the
// destination of a load sitting in EX. Writes to x0 never create a hazard.
module pipe_hazard_detect
  import rv32i_ctrl_pkg::*;
(
  input  logic [4:0] id_reg_s1,
  input  logic [4:0] id_reg_s2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_memLd,
  input  logic [4:0] ex_reg_d,
  output logic       ld_hazard
);

  always_comb begin
    ld_hazard = ex_memLd && (ex_reg_d != REG_X0) &&
                ((id_use_rs1 && (id_reg_s1 == ex_reg_d)) ||
                 (id_use_rs2 && (id_reg_s2 == ex_reg_d)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flush controller: arbitrates EX redirects, load-use stalls
// and data-memory waits. Define PIPE_HAZARD_CTRL_PERF_EN for perf counters.
module pipe_hazard_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned LOAD_LAT     = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rstB,
  input  logic             clkEn,
  input  logic [4:0]       id_reg_s1,
  input  logic [4:0]       id_reg_s2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memLd,
  input  logic [4:0]       ex_reg_d,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             stall,
  output logic             jmp,
  output logic             pc_hold,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  hazard_state_e state, state_n;
  logic [2:0]    cnt, cnt_n;
  logic          ld_hazard;

  pipe_hazard_detect u_detect (
    .id_reg_s1  (id_reg_s1),
    .id_reg_s2  (id_reg_s2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_memLd   (ex_memLd),
    .ex_reg_d   (ex_reg_d),
    .ld_hazard  (ld_hazard)
  );

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Outputs are gated by rstB as well so an asserted reset silences them
  // combinationally, not just after the state register clears.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    stall     = 1'b0;
    jmp       = 1'b0;
    ex_bubble = 1'b0;
    if (clkEn && rstB) begin
      unique case (state)
        RUN: begin
          if (ex_redirect) begin
            jmp = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              cnt_n   = 3'(FLUSH_CYCLES - 1);
              state_n = FLUSH;
            end
          end else if (dmem_req && !dmem_ack) begin
            stall   = 1'b1;
            state_n = MEM_WAIT;
          end else if (ld_hazard) begin
            stall     = 1'b1;
            ex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              cnt_n   = 3'(LOAD_LAT - 1);
              state_n = LD_STALL;
            end
          end
        end
        LD_STALL: begin
          if (ex_redirect) begin
            jmp = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              cnt_n   = 3'(FLUSH_CYCLES - 1);
              state_n = FLUSH;
            end else begin
              cnt_n   = '0;
              state_n = RUN;
            end
          end else begin
            stall     = 1'b1;
            ex_bubble = 1'b1;
            cnt_n     = cnt - 3'd1;
            if (cnt == 3'd1) state_n = RUN;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) state_n = RUN;
          else          stall   = 1'b1;
        end
        FLUSH: begin
          jmp = 1'b1;
          if (ex_redirect) begin
            cnt_n = 3'(FLUSH_CYCLES - 1);
          end else begin
            cnt_n = cnt - 3'd1;
            if (cnt == 3'd1) state_n = RUN;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  assign pc_hold = stall;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             flush_inc;

  // A redirect is accepted exactly when it produces jmp (MEM_WAIT suppresses both).
  assign flush_inc = jmp && ex_redirect;

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && (stall_q != '1))
        stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush_inc && (flush_q != '1))
        flush_q <= flush_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, LOAD_LAT=1).
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, rstB, clkEn;
  logic [4:0]  id_reg_s1, id_reg_s2, ex_reg_d;
  logic        id_use_rs1, id_use_rs2, ex_memLd, ex_redirect, dmem_req, dmem_ack;
  logic        stall, jmp, pc_hold, ex_bubble;
  logic [31:0] stall_cycles, flush_events;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_LAT(1), .CNT_W(32)) dut (
    .clk          (clk),
    .rstB         (rstB),
    .clkEn        (clkEn),
    .id_reg_s1    (id_reg_s1),
    .id_reg_s2    (id_reg_s2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_memLd     (ex_memLd),
    .ex_reg_d     (ex_reg_d),
    .ex_redirect  (ex_redirect),
    .dmem_req     (dmem_req),
    .dmem_ack     (dmem_ack),
    .stall        (stall),
    .jmp          (jmp),
    .pc_hold      (pc_hold),
    .ex_bubble    (ex_bubble),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic j, input logic b);
    chk({tag, ".stall"},     {31'd0, stall},     {31'd0, s});
    chk({tag, ".jmp"},       {31'd0, jmp},       {31'd0, j});
    chk({tag, ".pc_hold"},   {31'd0, pc_hold},   {31'd0, s});
    chk({tag, ".ex_bubble"}, {31'd0, ex_bubble}, {31'd0, b});
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".stall_cycles"}, stall_cycles, PERF ? exp_stall : 32'd0);
    chk({tag, ".flush_events"}, flush_events, PERF ? exp_flush : 32'd0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_reg_s1 = '0; id_reg_s2 = '0; ex_reg_d = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memLd = 1'b0;
    ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  initial begin
    idle_inputs();
    clkEn = 1'b1;
    rstB  = 1'b0;
    #12;
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    chk_cnt("reset");
    // hazard presented while in reset must not leak out
    ex_memLd = 1'b1; ex_reg_d = 5'd5; id_reg_s1 = 5'd5; id_use_rs1 = 1'b1; ex_redirect = 1'b1;
    #1;
    chk_out("reset_gate", 1'b0, 1'b0, 1'b0);
    idle_inputs();
    @(negedge clk);
    rstB = 1'b1;
    nxt();

    // load-use on rs1: single stall cycle, then RUN
    ex_memLd = 1'b1; ex_reg_d = 5'd5; id_reg_s1 = 5'd5; id_use_rs1 = 1'b1;
    #1; chk_out("ldu_rs1", 1'b1, 1'b0, 1'b1);
    nxt(); exp_stall++;
    idle_inputs();
    #1; chk_out("ldu_after", 1'b0, 1'b0, 1'b0);
    chk_cnt("ldu_cnt");

    // x0 destination never hazards
    nxt();
    ex_memLd = 1'b1; ex_reg_d = 5'd0; id_reg_s2 = 5'd0; id_use_rs2 = 1'b1;
    #1; chk_out("x0_dep", 1'b0, 1'b0, 1'b0);
    // match on rs1 but rs1 unused
    ex_reg_d = 5'd9; id_reg_s1 = 5'd9; id_use_rs1 = 1'b0; id_reg_s2 = 5'd3;
    #1; chk_out("rs1_unused", 1'b0, 1'b0, 1'b0);
    // rs2 match
    id_reg_s2 = 5'd9;
    #1; chk_out("ldu_rs2", 1'b1, 1'b0, 1'b1);
    nxt(); exp_stall++;
    idle_inputs();
    #1; chk_out("ldu_rs2_after", 1'b0, 1'b0, 1'b0);

    // redirect pulse: jmp for two cycles
    nxt();
    ex_redirect = 1'b1;
    #1; chk_out("redir_c0", 1'b0, 1'b1, 1'b0);
    nxt(); exp_flush++;
    ex_redirect = 1'b0;
    #1; chk_out("redir_c1", 1'b0, 1'b1, 1'b0);
    nxt();
    #1; chk_out("redir_c2", 1'b0, 1'b0, 1'b0);
    chk_cnt("redir_cnt");

    // memory wait: 4 stall cycles, redirect ignored while waiting
    dmem_req = 1'b1; dmem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ex_redirect = (i == 2);
      #1; chk_out($sformatf("memwait_%0d", i), 1'b1, 1'b0, 1'b0);
      nxt(); exp_stall++;
    end
    ex_redirect = 1'b0;
    dmem_ack = 1'b1;
    #1; chk_out("memwait_ack", 1'b0, 1'b0, 1'b0);
    nxt();
    dmem_req = 1'b0; dmem_ack = 1'b0;
    #1; chk_out("memwait_after", 1'b0, 1'b0, 1'b0);
    chk_cnt("memwait_cnt");
    // zero-latency memory
    dmem_req = 1'b1; dmem_ack = 1'b1;
    #1; chk_out("mem_zero_lat", 1'b0, 1'b0, 1'b0);
    nxt();
    idle_inputs();

    // priority: redirect beats load-use, then FLUSH masks the hazard
    ex_memLd = 1'b1; ex_reg_d = 5'd12; id_reg_s1 = 5'd12; id_use_rs1 = 1'b1;
    ex_redirect = 1'b1;
    #1; chk_out("prio_c0", 1'b0, 1'b1, 1'b0);
    nxt(); exp_flush++;
    ex_redirect = 1'b0;
    #1; chk_out("prio_flush", 1'b0, 1'b1, 1'b0);
    nxt();
    #1; chk_out("prio_run", 1'b1, 1'b0, 1'b1);
    nxt(); exp_stall++;
    idle_inputs();
    chk_cnt("prio_cnt");

    // back-to-back redirect reloads the flush count
    ex_redirect = 1'b1;
    #1; chk_out("reload_c0", 1'b0, 1'b1, 1'b0);
    nxt(); exp_flush++;
    #1; chk_out("reload_c1", 1'b0, 1'b1, 1'b0);
    nxt(); exp_flush++;
    ex_redirect = 1'b0;
    #1; chk_out("reload_c2", 1'b0, 1'b1, 1'b0);
    nxt();
    #1; chk_out("reload_c3", 1'b0, 1'b0, 1'b0);
    chk_cnt("reload_cnt");

    // clkEn low freezes FLUSH and silences outputs
    ex_redirect = 1'b1;
    #1; chk_out("clken_c0", 1'b0, 1'b1, 1'b0);
    nxt(); exp_flush++;
    ex_redirect = 1'b0; clkEn = 1'b0;
    #1; chk_out("clken_off", 1'b0, 1'b0, 1'b0);
    nxt();
    clkEn = 1'b1;
    #1; chk_out("clken_resume", 1'b0, 1'b1, 1'b0);
    nxt();
    #1; chk_out("clken_done", 1'b0, 1'b0, 1'b0);
    // clkEn low in RUN: no stall, no count
    clkEn = 1'b0; dmem_req = 1'b1;
    #1; chk_out("clken_run", 1'b0, 1'b0, 1'b0);
    nxt();
    clkEn = 1'b1; idle_inputs();
    #1; chk_out("clken_run_after", 1'b0, 1'b0, 1'b0);
    chk_cnt("clken_cnt");

    // asynchronous reset during FLUSH
    ex_redirect = 1'b1;
    #1; chk_out("rstflush_c0", 1'b0, 1'b1, 1'b0);
    nxt();
    ex_redirect = 1'b0;
    #1; chk_out("rstflush_c1", 1'b0, 1'b1, 1'b0);
    rstB = 1'b0;
    #1; chk_out("rstflush_async", 1'b0, 1'b0, 1'b0);
    exp_stall = 0; exp_flush = 0;
    chk_cnt("rstflush_cnt");
    @(negedge clk);
    rstB = 1'b1;
    nxt();
    #1; chk_out("rstflush_run", 1'b0, 1'b0, 1'b0);
    chk_cnt("rstflush_cnt2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline hazard and flush controller for the RV32I core.
- Drives the `stall` and `jmp` inputs of the instruction decoder.
- Also drives the EX-stage bubble insert and PC hold.
- Arbitrates three event sources: taken branch/jump redirect from EX, load-use dependency between ID and EX, and data-memory wait.
- Sits between fetch/decode and EX/MEM; one instance per core.

Parameters:
- FLUSH_CYCLES, 2, total cycles `jmp` is asserted per redirect (legal range 1..7).
- LOAD_LAT, 1, stall cycles inserted per load-use hazard (legal range 1..7).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rstB  in  1  reset, asynchronous, active-low
- clkEn  in  1  core advance enable; low freezes FSM and counters
- id_reg_s1  in  5  rs1 of instruction in ID
- id_reg_s2  in  5  rs2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_memLd  in  1  EX stage holds a load
- ex_reg_d  in  5  rd of EX stage instruction
- ex_redirect  in  1  EX resolved taken branch, jal or jalr
- dmem_req  in  1  MEM stage data-memory request
- dmem_ack  in  1  data-memory completion
- stall  out  1  hold ID/IF (to decoder `stall`)
- jmp  out  1  squash ID (to decoder `jmp`)
- pc_hold  out  1  freeze PC register
- ex_bubble  out  1  inject NOP into EX
- stall_cycles  out  CNT_W  performance counter
- flush_events  out  CNT_W  performance counter

Behaviour:
- Clock and reset: one clock `clk`; reset `rstB` is asynchronous and active-low.
- Reset values: state=RUN, cnt=0, all outputs 0, both perf counters 0. Reset asserted mid-stall or mid-flush aborts immediately with no residual stall or jmp.
- `stall`, `jmp`, `pc_hold`, `ex_bubble` are Mealy outputs of state and current inputs; they are 0 while rstB=0.
- `pc_hold` = `stall`.
- ld_hazard = ex_memLd & (ex_reg_d!=0) & ((id_use_rs1 & id_reg_s1==ex_reg_d) | (id_use_rs2 & id_reg_s2==ex_reg_d)).
- FSM states: RUN, LD_STALL, MEM_WAIT, FLUSH. The 3-bit counter cnt is shared between LD_STALL and FLUSH.
- RUN, event priority (highest first):
  1. ex_redirect: jmp=1 this cycle. If FLUSH_CYCLES>1, cnt<=FLUSH_CYCLES-1 and go to FLUSH.
  2. dmem_req & !dmem_ack: stall=1, go to MEM_WAIT.
  3. ld_hazard: stall=1, ex_bubble=1. If LOAD_LAT>1, cnt<=LOAD_LAT-1 and go to LD_STALL.
- LD_STALL: stall=1, ex_bubble=1, cnt decrements each cycle; go to RUN when cnt reaches 1→0. ex_redirect here aborts the stall: jmp=1 and enter FLUSH exactly as from RUN.
- MEM_WAIT: stall=1 while dmem_ack=0. On dmem_ack=1, stall=0 in that same cycle and go to RUN. ex_redirect is ignored here (EX is frozen).
- FLUSH: jmp=1, cnt decrements; go to RUN when cnt reaches 0. A new ex_redirect reloads cnt to FLUSH_CYCLES-1. stall=0 throughout.
- Simultaneous jmp and stall are never both 1 in one cycle.
- clkEn=0: state and cnt hold, no new event is accepted, all Mealy outputs are 0.
- Zero-latency memory: dmem_req with dmem_ack in the same cycle produces no stall.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle with stall=1 and clkEn=1.
  - flush_events increments on each ex_redirect accepted (RUN, LD_STALL or FLUSH).
  - Both counters saturate at all-ones and reset to 0.
- Undefined: both ports are tied to 0; no counter flops are synthesised.

Decomposition:
- Package rv32i_ctrl_pkg:
  - hazard_state_e enum (RUN, LD_STALL, MEM_WAIT, FLUSH).
  - OPC_* 7-bit opcode constants shared with the decoder.
  - REG_X0 = 5'd0.
- Sub-module pipe_hazard_detect: purely combinational ld_hazard compare, reusable by a future forwarding unit.

Test Plan:
1. Load-use, LOAD_LAT=1: ex_memLd=1, ex_reg_d=5, id_reg_s1=5, id_use_rs1=1 → stall and ex_bubble high exactly 1 cycle, back in RUN next cycle.
2. x0 dependency: ex_reg_d=0, id_reg_s2=0, id_use_rs2=1, ex_memLd=1 → stall stays 0.
3. Redirect, FLUSH_CYCLES=2: ex_redirect pulse 1 cycle → jmp high 2 consecutive cycles, stall 0, flush_events +1 (macro on).
4. Memory wait: dmem_req=1, dmem_ack held 0 for 4 cycles then 1 → stall high 4 cycles, low in the ack cycle; stall_cycles +4.
5. Priority: ex_redirect and ld_hazard in the same RUN cycle → jmp=1, stall=0, FSM enters FLUSH.
6. Reset mid-FLUSH: rstB low asynchronously during a jmp cycle → jmp drops immediately; after release, state is RUN and counters read 0.
